// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory FSM (IDLE/BUSY/DONE) with pipeline stall and MEM/WB register.
// Define MEM_TIMEOUT_EN to bound BUSY to TIMEOUT_CYCLES and raise a sticky err_o.
module mem_access_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_r_i,
    input  logic                  w_mem_ena_i,
    input  logic [DATA_WIDTH-1:0] alu_res_i,
    input  logic [DATA_WIDTH-1:0] rt_data_i,
    input  logic [4:0]            rd_i,
    input  logic                  w_reg_ena_i,
    input  logic                  wb_sel_i,
    output logic                  stall_o,
    output logic                  dm_req_o,
    output logic                  dm_we_o,
    output logic [DATA_WIDTH-1:0] dm_addr_o,
    output logic [DATA_WIDTH-1:0] dm_wdata_o,
    input  logic                  dm_ack_i,
    input  logic [DATA_WIDTH-1:0] dm_rdata_i,
    output logic                  wb_valid_o,
    output logic                  wb_w_reg_ena_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic [4:0]            wb_rd_o,
    output logic                  err_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t                state_q;
    logic                  access, to_hit, to_q;
    logic                  dm_req_q, dm_we_q, wb_valid_q, wb_wen_q;
    logic [DATA_WIDTH-1:0] dm_addr_q, dm_wdata_q, rdata_q, wb_data_q, wb_data_d;
    logic [4:0]            wb_rd_q;

    assign access    = mem_r_i | w_mem_ena_i;
    assign stall_o   = (state_q == IDLE && access) || state_q == BUSY;
    assign wb_data_d = to_q ? '0 : wb_sel_i ? rdata_q : alu_res_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            rdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_wen_q   <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (access) begin
                    state_q    <= BUSY;
                    dm_req_q   <= 1'b1;
                    dm_we_q    <= w_mem_ena_i & ~mem_r_i;
                    dm_addr_q  <= alu_res_i;
                    dm_wdata_q <= rt_data_i;
                end
                BUSY: if (dm_ack_i || to_hit) begin
                    // a timed-out access leaves rdata_q untouched; to_q zeroes the write-back instead
                    if (dm_ack_i) rdata_q <= dm_rdata_i;
                    state_q  <= DONE;
                    dm_req_q <= 1'b0;
                    dm_we_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
            wb_valid_q <= !stall_o;
            wb_wen_q   <= !stall_o && w_reg_ena_i && !to_q;
            if (!stall_o) begin
                wb_data_q <= wb_data_d;
                wb_rd_q   <= rd_i;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;

    assign to_hit = state_q == BUSY && !dm_ack_i && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign err_o  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= (state_q == BUSY && !dm_ack_i && !to_hit) ? cnt_q + CW'(1) : '0;
            err_q <= err_q | to_hit;
            to_q  <= to_hit;
        end
    end
`else
    assign to_hit = 1'b0;
    assign to_q   = 1'b0;
    assign err_o  = 1'b0;
`endif

    assign dm_req_o       = dm_req_q;
    assign dm_we_o        = dm_we_q;
    assign dm_addr_o      = dm_addr_q;
    assign dm_wdata_o     = dm_wdata_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_w_reg_ena_o = wb_wen_q;
    assign wb_data_o      = wb_data_q;
    assign wb_rd_o        = wb_rd_q;
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of address/data paths (equals INSTR_WIDTH).
REQ-002 Parameter TIMEOUT_CYCLES, 16, BUSY-state cycle limit (used only with MEM_TIMEOUT_EN).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 mem_r_i  in  1  EX/MEM load flag.
REQ-006 w_mem_ena_i  in  1  EX/MEM store flag.
REQ-007 alu_res_i  in  DATA_WIDTH  EX/MEM ALU result / memory address.
REQ-008 rt_data_i  in  DATA_WIDTH  EX/MEM store data.
REQ-009 rd_i  in  5  EX/MEM destination register.
REQ-010 w_reg_ena_i  in  1  EX/MEM register-write enable.
REQ-011 wb_sel_i  in  1  1 = write back load data, 0 = write back ALU result.
REQ-012 stall_o  out  1  freeze request to EX/MEM and upstream pipeline registers (active high).
REQ-013 dm_req_o, dm_we_o  out  1 each  data-memory request / write strobe.
REQ-014 dm_addr_o, dm_wdata_o  out  DATA_WIDTH each  data-memory address / write data.
REQ-015 dm_ack_i  in  1  data-memory completion; dm_rdata_i  in  DATA_WIDTH  read data, valid with ack.
REQ-016 wb_valid_o, wb_w_reg_ena_o  out  1 each  MEM/WB valid / register-write enable.
REQ-017 wb_data_o  out  DATA_WIDTH; wb_rd_o  out  5  write-back value / destination.
REQ-018 err_o  out  1  sticky memory-timeout flag.

Function
REQ-019 FSM states IDLE, BUSY, DONE; access_i = mem_r_i | w_mem_ena_i.
REQ-020 IDLE with access_i: stall_o = 1 combinationally, latch address/data/type, next BUSY.
REQ-021 BUSY: dm_req_o = 1, stall_o = 1; address/wdata/we held stable from latches until ack.
REQ-022 BUSY with dm_ack_i: capture dm_rdata_i (loads), drop dm_req_o next cycle, next DONE.
REQ-023 DONE: stall_o = 0 for exactly one cycle, no new request issued; next IDLE.
REQ-024 Minimum memory access: stall high 2 cycles (IDLE, BUSY with same-cycle ack); each extra ack-wait cycle adds one.
REQ-025 dm_we_o = 1 only for stores; mem_r_i and w_mem_ena_i both high SHALL be treated as load (dm_we_o = 0).
REQ-026 IDLE without access_i: stall_o = 0, no request; instruction passes with zero stall.
REQ-027 MEM/WB outputs register on every edge where stall_o = 0: wb_valid_o = 1, wb_rd_o = rd, wb_w_reg_ena_o = w_reg_ena, wb_data_o = wb_sel ? load data : alu_res.
REQ-028 Edges with stall_o = 1: wb_valid_o = 0 and wb_w_reg_ena_o = 0 (bubble), other wb outputs hold.
REQ-029 dm_ack_i in IDLE or DONE SHALL be ignored.

Reset
REQ-030 rst low forces IDLE immediately, regardless of state, including mid-transaction.
REQ-031 Reset values: stall_o 0 (inputs idle), dm_req_o 0, dm_we_o 0, dm_addr_o 0, dm_wdata_o 0, wb_valid_o 0, wb_w_reg_ena_o 0, wb_data_o 0, wb_rd_o 0, err_o 0, timeout counter 0.

Configuration
REQ-032 Macro MEM_TIMEOUT_EN defined: counter increments each BUSY cycle; reaching TIMEOUT_CYCLES without ack drops dm_req_o, goes DONE, sets err_o until reset, forces wb_w_reg_ena_o = 0 and wb_data_o = 0 for that instruction.
REQ-033 MEM_TIMEOUT_EN undefined: BUSY waits indefinitely for dm_ack_i; err_o tied 0; no counter logic.

Verification
REQ-034 Load addr 0x100, ack in first BUSY cycle, rdata 0xDEADBEEF, wb_sel 1, rd 5 -> stall 2 cycles, then wb_data_o 0xDEADBEEF, wb_rd_o 5, wb_valid_o 1.
REQ-035 Store addr 0x40, data 0x1234, ack after 3 BUSY cycles -> dm_we_o 1, addr/data stable 3 cycles, stall 4 cycles, wb_w_reg_ena_o 0.
REQ-036 Back-to-back ALU ops, alu_res 7 then 9 -> stall_o never high, wb_data_o 7 then 9 on consecutive cycles.
REQ-037 Reset low during BUSY -> dm_req_o 0 and state IDLE same cycle, all outputs at reset values.
REQ-038 MEM_TIMEOUT_EN, TIMEOUT_CYCLES 16, no ack -> dm_req_o drops after 16 BUSY cycles, err_o 1 and sticky, wb_w_reg_ena_o 0.
REQ-039 Spurious dm_ack_i in IDLE with no access -> no state change, no wb data change beyond pass-through.
